// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the generic pipeline stage register (pipe_stage_reg)
// and its capture mux (pipe_fwd_mux).
//
// Contents:
//   - default parameter values for a stage instance
//   - stage identifiers and the per-stage bubble (NOP) control words
//   - bit offsets/widths of the fields inside the packed control word
//   - channel-slicing helpers for the packed operand bus (pipe_ops_t layout:
//     channel i occupies bits [i*DATA_W +: DATA_W])
//
// Also defines the macro `PIPE_OPS_CH(vec, ch, w) for slicing one operand
// channel out of a packed operand vector.
// -----------------------------------------------------------------------------
`ifndef PIPE_PKG_SV
`define PIPE_PKG_SV

// Slice operand channel `ch` (width `w`) out of packed operand vector `vec`.
`define PIPE_OPS_CH(vec, ch, w) vec[(ch)*(w) +: (w)]

package pipe_pkg;

  // Default geometry of a stage register.
  localparam int PIPE_DATA_W_DEF  = 32;
  localparam int PIPE_NUM_OPS_DEF = 2;
  localparam int PIPE_CTRL_W_DEF  = 24;
  localparam int PIPE_CNT_W_DEF   = 16;
  localparam int PIPE_MAX_OPS     = 4;

  // Stage boundaries a pipe_stage_reg can sit on.
  typedef enum logic [1:0] {
    STAGE_IF_ID  = 2'd0,
    STAGE_ID_EX  = 2'd1,
    STAGE_EX_MEM = 2'd2,
    STAGE_MEM_WB = 2'd3
  } pipe_stage_e;

  // Field layout of the default 24-bit control word.
  // Every write-enable style field is active-high, so an all-zero word is a
  // safe "no writes" bubble.
  localparam int CTRL_REG_WE_BIT  = 0;   // register file write enable
  localparam int CTRL_MEM_WE_BIT  = 1;   // data memory write enable
  localparam int CTRL_MEM_RE_BIT  = 2;   // data memory read enable
  localparam int CTRL_BRANCH_BIT  = 3;   // conditional branch
  localparam int CTRL_JUMP_BIT    = 4;   // unconditional jump
  localparam int CTRL_ALU_OP_LSB  = 5;
  localparam int CTRL_ALU_OP_W    = 4;
  localparam int CTRL_RD_LSB      = 9;   // destination register index
  localparam int CTRL_RD_W        = 5;
  localparam int CTRL_IMM_SEL_LSB = 14;
  localparam int CTRL_IMM_SEL_W   = 3;
  localparam int CTRL_WB_SEL_LSB  = 17;
  localparam int CTRL_WB_SEL_W    = 2;
  localparam int CTRL_CSR_WE_BIT  = 19;  // CSR write enable
  localparam int CTRL_RSVD_LSB    = 20;
  localparam int CTRL_RSVD_W      = 4;

  // Per-stage bubble control words. All write enables are clear; the
  // remaining fields are don't-care for a bubble and kept at zero.
  localparam logic [PIPE_CTRL_W_DEF-1:0] NOP_CTRL_IF_ID  = '0;
  localparam logic [PIPE_CTRL_W_DEF-1:0] NOP_CTRL_ID_EX  = '0;
  localparam logic [PIPE_CTRL_W_DEF-1:0] NOP_CTRL_EX_MEM = '0;
  localparam logic [PIPE_CTRL_W_DEF-1:0] NOP_CTRL_MEM_WB = '0;

  // Bubble control word for a given stage boundary.
  function automatic logic [PIPE_CTRL_W_DEF-1:0] nop_ctrl_for(input pipe_stage_e stage);
    logic [PIPE_CTRL_W_DEF-1:0] nop;
    case (stage)
      STAGE_IF_ID:  nop = NOP_CTRL_IF_ID;
      STAGE_ID_EX:  nop = NOP_CTRL_ID_EX;
      STAGE_EX_MEM: nop = NOP_CTRL_EX_MEM;
      default:      nop = NOP_CTRL_MEM_WB;
    endcase
    return nop;
  endfunction

  // True when a control word requests any architectural write.
  function automatic logic ctrl_has_write(input logic [PIPE_CTRL_W_DEF-1:0] ctrl);
    return ctrl[CTRL_REG_WE_BIT] | ctrl[CTRL_MEM_WE_BIT] | ctrl[CTRL_CSR_WE_BIT];
  endfunction

  // LSB of operand channel `ch` in a packed operand bus of width `w` per channel.
  function automatic int unsigned ops_lsb(input int unsigned ch, input int unsigned w);
    return ch * w;
  endfunction

endpackage

`endif

// File: rtl/pipe_fwd_mux.sv
// -----------------------------------------------------------------------------
// pipe_fwd_mux
// Single-channel operand capture mux. Selects the hazard-unit bypass value
// instead of the upstream operand when the channel's forward select is set.
// pipe_stage_reg instantiates one per operand channel.
//
// Ports:
//   i_sel  in   1       1: take i_fwd, 0: take i_op
//   i_op   in   DATA_W  upstream operand
//   i_fwd  in   DATA_W  bypass value
//   o_op   out  DATA_W  selected operand
// -----------------------------------------------------------------------------
module pipe_fwd_mux
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W_DEF
) (
  input  logic              i_sel,
  input  logic [DATA_W-1:0] i_op,
  input  logic [DATA_W-1:0] i_fwd,
  output logic [DATA_W-1:0] o_op
);

  assign o_op = i_sel ? i_fwd : i_op;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Parametrised pipeline stage register with valid/ready flow control,
// flush-to-bubble, per-channel forwarding capture and a saturating stall
// counter. Sits between any two core stages.
//
// Optional feature: define PIPE_SKID_EN to add a one-entry skid register so
// that in_ready comes straight from a flop (no combinational path from
// out_ready). Without it, in_ready = !out_valid || out_ready.
//
// Ports:
//   clk        in   1               clock, rising edge
//   rst_n      in   1               asynchronous active-low reset
//   in_valid   in   1               upstream payload valid
//   in_ready   out  1               stage can accept this cycle
//   in_ctrl    in   CTRL_W          upstream control word
//   in_ops     in   NUM_OPS*DATA_W  upstream operands, channel i at [i*DATA_W +: DATA_W]
//   fwd_sel    in   NUM_OPS         per-channel: capture fwd_data instead of in_ops
//   fwd_data   in   NUM_OPS*DATA_W  bypass values
//   flush      in   1               kill contents, insert bubble (highest priority)
//   out_valid  out  1               downstream payload valid
//   out_ready  in   1               downstream accepts
//   out_ctrl   out  CTRL_W          registered control, NOP_CTRL when not valid
//   out_ops    out  NUM_OPS*DATA_W  registered operands, zero when not valid
//   stall_cnt  out  CNT_W           saturating count of out_valid && !out_ready cycles
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = PIPE_DATA_W_DEF,
  parameter int                NUM_OPS  = PIPE_NUM_OPS_DEF,
  parameter int                CTRL_W   = PIPE_CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}},
  parameter int                CNT_W    = PIPE_CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [NUM_OPS*DATA_W-1:0] in_ops,
  input  logic [NUM_OPS-1:0]        fwd_sel,
  input  logic [NUM_OPS*DATA_W-1:0] fwd_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [NUM_OPS*DATA_W-1:0] out_ops,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int OPS_W = NUM_OPS * DATA_W;

  // ---------------------------------------------------------------------------
  // Capture mux: one per operand channel. Its result is only sampled on an
  // input transfer, so held contents never see later fwd_* changes.
  // ---------------------------------------------------------------------------
  logic [OPS_W-1:0] w_cap_ops;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    pipe_fwd_mux #(
      .DATA_W (DATA_W)
    ) u_fwd_mux (
      .i_sel (fwd_sel[g]),
      .i_op  (in_ops[g*DATA_W +: DATA_W]),
      .i_fwd (fwd_data[g*DATA_W +: DATA_W]),
      .o_op  (w_cap_ops[g*DATA_W +: DATA_W])
    );
  end

  // ---------------------------------------------------------------------------
  // Main register and flow-control terms
  // ---------------------------------------------------------------------------
  logic              r_out_valid;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [OPS_W-1:0]  r_out_ops;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_main_free;  // main register is empty or drains this cycle
  logic w_in_xfer;    // upstream handshake completes this cycle
  logic w_stall;      // valid payload blocked by downstream, no flush

  assign w_main_free = !r_out_valid || out_ready;
  assign w_in_xfer   = in_valid && in_ready;
  assign w_stall     = r_out_valid && !out_ready && !flush;

`ifdef PIPE_SKID_EN
  // ---------------------------------------------------------------------------
  // Skid build: one extra entry catches the word accepted while main is held.
  // in_ready depends only on skid occupancy, which is a flop.
  // ---------------------------------------------------------------------------
  logic              r_skid_valid;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [OPS_W-1:0]  r_skid_ops;

  assign in_ready = !r_skid_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_ctrl   <= NOP_CTRL;
      r_out_ops    <= '0;
      r_skid_valid <= 1'b0;
      // NOTE: the skid payload is reset too even though r_skid_valid gates it;
      // it is a single entry, so a deterministic value after reset costs nothing.
      r_skid_ctrl  <= NOP_CTRL;
      r_skid_ops   <= '0;
    end else if (flush) begin
      // Flush beats everything: bubble in main, skid dropped, input discarded.
      r_out_valid  <= 1'b0;
      r_out_ctrl   <= NOP_CTRL;
      r_out_ops    <= '0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        // Older word waiting in skid goes first to preserve order. in_ready is
        // low while skid is occupied, so no new input competes here.
        r_out_valid  <= 1'b1;
        r_out_ctrl   <= r_skid_ctrl;
        r_out_ops    <= r_skid_ops;
        r_skid_valid <= 1'b0;
      end else if (w_in_xfer) begin
        r_out_valid <= 1'b1;
        r_out_ctrl  <= in_ctrl;
        r_out_ops   <= w_cap_ops;
      end else begin
        r_out_valid <= 1'b0;
        r_out_ctrl  <= NOP_CTRL;
        r_out_ops   <= '0;
      end
    end else if (w_in_xfer) begin
      // Main is held; park the accepted word in skid.
      r_skid_valid <= 1'b1;
      r_skid_ctrl  <= in_ctrl;
      r_skid_ops   <= w_cap_ops;
    end
  end

`else
  // ---------------------------------------------------------------------------
  // No-skid build: legacy latch behaviour, in_ready is combinational.
  // ---------------------------------------------------------------------------
  assign in_ready = w_main_free;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= NOP_CTRL;
      r_out_ops   <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= NOP_CTRL;
      r_out_ops   <= '0;
    end else if (w_in_xfer) begin
      // in_ready already implies the main register is free or draining.
      r_out_valid <= 1'b1;
      r_out_ctrl  <= in_ctrl;
      r_out_ops   <= w_cap_ops;
    end else if (w_main_free) begin
      // Drained (or already empty) with nothing new: present a bubble.
      r_out_valid <= 1'b0;
      r_out_ctrl  <= NOP_CTRL;
      r_out_ops   <= '0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Stall counter: saturates at all-ones, survives flush.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_ctrl  = r_out_ctrl;
  assign out_ops   = r_out_ops;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Directed testbench for pipe_stage_reg. Uses CNT_W=4 so counter saturation is
// reachable quickly, and a non-zero NOP_CTRL so bubbles are distinguishable
// from a zero control word. Expectations adapt to PIPE_SKID_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_stage_reg;

  localparam int                DATA_W  = 32;
  localparam int                NUM_OPS = 2;
  localparam int                CTRL_W  = 24;
  localparam int                CNT_W   = 4;
  localparam logic [CTRL_W-1:0] NOP     = 24'h800000;

  logic                      clk;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  logic [CTRL_W-1:0]         in_ctrl;
  logic [NUM_OPS*DATA_W-1:0] in_ops;
  logic [NUM_OPS-1:0]        fwd_sel;
  logic [NUM_OPS*DATA_W-1:0] fwd_data;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [CTRL_W-1:0]         out_ctrl;
  logic [NUM_OPS*DATA_W-1:0] out_ops;
  logic [CNT_W-1:0]          stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg #(
    .DATA_W   (DATA_W),
    .NUM_OPS  (NUM_OPS),
    .CTRL_W   (CTRL_W),
    .NOP_CTRL (NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_ops    (in_ops),
    .fwd_sel   (fwd_sel),
    .fwd_data  (fwd_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_ops   (out_ops),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] o0, input logic [DATA_W-1:0] o1);
    in_valid = v;
    in_ctrl  = c;
    in_ops   = {o1, o0};
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_ops    = '0;
    fwd_sel   = '0;
    fwd_data  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_ctrl !== NOP) begin n_fail++; $display("FAIL reset_ctrl: got %h expected %h", out_ctrl, NOP); end
    n_checks++; if (out_ops !== '0) begin n_fail++; $display("FAIL reset_ops: got %h expected 0", out_ops); end
    n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stream();
    logic [DATA_W-1:0] exp_o0;
    logic [DATA_W-1:0] exp_o1;
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp_o0 = 32'h1000 + 32'(i);
      exp_o1 = 32'h2000 + 32'(i);
      drive(1'b1, 24'(i), exp_o0, exp_o1);
      tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, out_valid); end
      n_checks++; if (out_ctrl !== 24'(i)) begin n_fail++; $display("FAIL stream_ctrl[%0d]: got %h expected %h", i, out_ctrl, 24'(i)); end
      n_checks++; if (out_ops !== {exp_o1, exp_o0}) begin n_fail++; $display("FAIL stream_ops[%0d]: got %h expected %h", i, out_ops, {exp_o1, exp_o0}); end
    end
    drive(1'b0, 24'h0, 32'h0, 32'h0);
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_ctrl !== NOP) begin n_fail++; $display("FAIL stream_drain_ctrl: got %h expected %h", out_ctrl, NOP); end
    n_checks++; if (out_ops !== '0) begin n_fail++; $display("FAIL stream_drain_ops: got %h expected 0", out_ops); end
    n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL stream_stall: got %0d expected 0", stall_cnt); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_fwd_capture();
    logic [1:0]                sel_tab [3];
    logic [NUM_OPS*DATA_W-1:0] exp_tab [3];
    sel_tab[0] = 2'b01; exp_tab[0] = {32'h22, 32'hAA};
    sel_tab[1] = 2'b10; exp_tab[1] = {32'hBB, 32'h11};
    sel_tab[2] = 2'b11; exp_tab[2] = {32'hBB, 32'hAA};
    do_reset();
    out_ready = 1'b1;
    fwd_data  = {32'hBB, 32'hAA};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 24'h40 + 24'(i), 32'h11, 32'h22);
      fwd_sel = sel_tab[i];
      tick();
      n_checks++; if (out_ops !== exp_tab[i]) begin n_fail++; $display("FAIL fwd_ops[%0d]: got %h expected %h", i, out_ops, exp_tab[i]); end
    end
    drive(1'b0, 24'h0, 32'h0, 32'h0);
    fwd_sel = '0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    logic [NUM_OPS*DATA_W-1:0] w1_ops;
    w1_ops = {32'h101, 32'h100};
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 24'h10, 32'h100, 32'h101);
    tick();
    n_checks++; if (out_ctrl !== 24'h10) begin n_fail++; $display("FAIL bp_load_ctrl: got %h expected 10", out_ctrl); end
    out_ready = 1'b0;
    drive(1'b1, 24'h20, 32'h200, 32'h201);
    #1;
`ifdef PIPE_SKID_EN
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_skid_free: got %b expected 1", in_ready); end
`else
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_held: got %b expected 0", in_ready); end
`endif
    for (int i = 1; i <= 5; i++) begin
      tick();
      // After the first stalled edge the skid entry (if any) is full.
      drive(1'b1, 24'h30, 32'h300, 32'h301);
      fwd_sel  = 2'b11;
      fwd_data = {32'hDEAD0000 + 32'(i), 32'hBEEF0000 + 32'(i)};
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, out_valid); end
      n_checks++; if (out_ctrl !== 24'h10) begin n_fail++; $display("FAIL bp_hold_ctrl[%0d]: got %h expected 10", i, out_ctrl); end
      n_checks++; if (out_ops !== w1_ops) begin n_fail++; $display("FAIL bp_hold_ops[%0d]: got %h expected %h", i, out_ops, w1_ops); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready[%0d]: got %b expected 0", i, in_ready); end
    end
    n_checks++; if (stall_cnt !== 4'd5) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d expected 5", stall_cnt); end
    fwd_sel   = '0;
    out_ready = 1'b1;
    tick();
`ifdef PIPE_SKID_EN
    n_checks++; if (out_ctrl !== 24'h20) begin n_fail++; $display("FAIL bp_skid_out_ctrl: got %h expected 20", out_ctrl); end
    n_checks++; if (out_ops !== {32'h201, 32'h200}) begin n_fail++; $display("FAIL bp_skid_out_ops: got %h expected %h", out_ops, {32'h201, 32'h200}); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_skid_ready_back: got %b expected 1", in_ready); end
    tick();
`endif
    n_checks++; if (out_ctrl !== 24'h30) begin n_fail++; $display("FAIL bp_next_ctrl: got %h expected 30", out_ctrl); end
    n_checks++; if (out_ops !== {32'h301, 32'h300}) begin n_fail++; $display("FAIL bp_next_ops: got %h expected %h", out_ops, {32'h301, 32'h300}); end
    drive(1'b0, 24'h0, 32'h0, 32'h0);
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end_valid: got %b expected 0", out_valid); end
    n_checks++; if (stall_cnt !== 4'd5) begin n_fail++; $display("FAIL bp_end_stall: got %0d expected 5", stall_cnt); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 24'h10, 32'h100, 32'h101);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 24'h20, 32'h200, 32'h201);
    tick();
    // Flush while stalled (skid full in the skid build) with a new word offered.
    drive(1'b1, 24'h30, 32'h300, 32'h301);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 24'h0, 32'h0, 32'h0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_ctrl !== NOP) begin n_fail++; $display("FAIL flush_ctrl: got %h expected %h", out_ctrl, NOP); end
    n_checks++; if (out_ops !== '0) begin n_fail++; $display("FAIL flush_ops: got %h expected 0", out_ops); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL flush_stall_kept: got %0d expected 1", stall_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_skid_emit[%0d]: got %b expected 0", i, out_valid); end
    end
    // Flush coincident with an input transfer discards the input.
    drive(1'b1, 24'h50, 32'h500, 32'h501);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 24'h0, 32'h0, 32'h0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_xfer_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_ctrl !== NOP) begin n_fail++; $display("FAIL flush_xfer_ctrl: got %h expected %h", out_ctrl, NOP); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_xfer_after: got %b expected 0", out_valid); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 24'h60, 32'h600, 32'h601);
    tick();
    drive(1'b0, 24'h0, 32'h0, 32'h0);
    out_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) begin
        n_checks++; if (stall_cnt !== 4'd14) begin n_fail++; $display("FAIL sat_cnt14: got %0d expected 14", stall_cnt); end
      end
      if (i == 15) begin
        n_checks++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_cnt15: got %0d expected 15", stall_cnt); end
      end
    end
    n_checks++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_cnt20: got %0d expected 15", stall_cnt); end
    n_checks++; if (out_ctrl !== 24'h60) begin n_fail++; $display("FAIL sat_hold_ctrl: got %h expected 60", out_ctrl); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_drain_valid: got %b expected 0", out_valid); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 24'h70, 32'h700, 32'h701);
    tick();
    drive(1'b0, 24'h0, 32'h0, 32'h0);
    out_ready = 1'b0;
    tick();
    tick();
    n_checks++; if (stall_cnt !== 4'd2) begin n_fail++; $display("FAIL arst_pre_stall: got %0d expected 2", stall_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_ctrl !== NOP) begin n_fail++; $display("FAIL arst_ctrl: got %h expected %h", out_ctrl, NOP); end
    n_checks++; if (out_ops !== '0) begin n_fail++; $display("FAIL arst_ops: got %h expected 0", out_ops); end
    n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL arst_stall: got %0d expected 0", stall_cnt); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready: got %b expected 1", in_ready); end
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 24'h80, 32'h800, 32'h801);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_release_valid: got %b expected 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_first_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_ctrl !== 24'h80) begin n_fail++; $display("FAIL arst_first_ctrl: got %h expected 80", out_ctrl); end
    n_checks++; if (out_ops !== {32'h801, 32'h800}) begin n_fail++; $display("FAIL arst_first_ops: got %h expected %h", out_ops, {32'h801, 32'h800}); end
    drive(1'b0, 24'h0, 32'h0, 32'h0);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_fwd_capture();
    test_backpressure();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the generalised successor of the fixed ID/EX latch. It carries a control word and `NUM_OPS` operand channels across one stage boundary. It adds valid/ready flow control, flush-to-bubble, per-channel forwarding capture and a saturating stall counter. It is instantiated between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- `DATA_W`, 32, width of each operand channel
- `NUM_OPS`, 2, number of operand channels (1..4)
- `CTRL_W`, 24, width of the packed control word
- `NOP_CTRL`, `{CTRL_W{1'b0}}`, control value driven for a bubble (must encode "no writes")
- `CNT_W`, 16, stall counter width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream has a valid instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_ctrl`  in  CTRL_W  upstream control word
- `in_ops`  in  NUM_OPS*DATA_W  upstream operands; channel i = bits [i*DATA_W +: DATA_W]
- `fwd_sel`  in  NUM_OPS  bit i set: capture `fwd_data` channel i instead of `in_ops` channel i
- `fwd_data`  in  NUM_OPS*DATA_W  hazard-unit bypass values
- `flush`  in  1  kill contents, insert bubble
- `out_valid`  out  1  downstream payload valid
- `out_ready`  in  1  downstream accepts
- `out_ctrl`  out  CTRL_W  registered control (`NOP_CTRL` when not valid)
- `out_ops`  out  NUM_OPS*DATA_W  registered operands
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`, saturating

## Operation
- Input transfer is `in_valid && in_ready`. Output transfer is `out_valid && out_ready`.
- Capture mux per channel i: `fwd_sel[i] ? fwd_data[i] : in_ops[i]`. It is applied only at input transfer. Captured values never change while held.
- Main register loads on input transfer when empty or draining: `!out_valid || out_ready`.
- Held register: `out_valid && !out_ready` keeps `out_*` stable, bit-exact.
- Bubble: when not valid, `out_ctrl = NOP_CTRL` and `out_ops = 0`. Downstream may ignore `out_valid` and still be safe.
- Flush has priority over every other event in the same cycle:
  - next `out_valid = 0`, `out_ctrl = NOP_CTRL`, `out_ops = 0`
  - any skid entry is cleared
  - a coincident input transfer is discarded
  - `stall_cnt` is not cleared
- `stall_cnt` increments each cycle with `out_valid && !out_ready && !flush`. It saturates at `2^CNT_W-1` and does not wrap.

## Timing
- Reset (asynchronous, `rst_n` low): `out_valid=0`, `out_ctrl=NOP_CTRL`, `out_ops=0`, `stall_cnt=0`, skid empty. `in_ready` follows its defining equation, which evaluates to 1.
- Reset mid-operation discards all contents immediately, with no partial outputs.
- Latency: input transfer at edge N gives `out_valid` after edge N. Throughput is 1 per cycle with `out_ready` held high.
- Simultaneous output and input transfer: the new payload replaces the old at the same edge, with no bubble.
- `flush` and `out_ready=0` together: the bubble wins, and `out_valid` falls after the edge.

## Configuration
- `PIPE_SKID_EN` defined:
  - A one-entry skid register is added and `in_ready = !skid_valid` comes straight from a flop, with no combinational path from `out_ready`.
  - An input accepted while the main register is held goes to skid.
  - Skid moves to main on the next output transfer, and skid has priority over new input.
  - Order is preserved.
- `PIPE_SKID_EN` undefined:
  - There is no skid.
  - `in_ready = !out_valid || out_ready`, a combinational path.
  - Behaviour otherwise matches the legacy ID/EX latch with `clear` mapped to `flush` and stall mapped to `!out_ready`.

## Structure
- Shared package `pipe_pkg`:
  - `NOP_CTRL` defaults per stage
  - control-word field offsets
  - `pipe_ops_t` helper macros for channel slicing
- One sub-module, `pipe_fwd_mux`: a per-channel capture mux, generated `NUM_OPS` times.
- Skid logic stays inline under `ifdef PIPE_SKID_EN`.

## Test plan
- Reset then stream: `in_valid=1`, `out_ready=1`, ctrl 1,2,3 on consecutive cycles -> `out_ctrl` 1,2,3 one cycle later each, `out_valid` continuous, `stall_cnt=0`.
- Forward capture: `in_ops` ch0=0x11, `fwd_sel=2'b01`, `fwd_data` ch0=0xAA -> `out_ops` ch0=0xAA, ch1 = `in_ops` ch1.
- Backpressure: `out_ready=0` for 5 cycles with a valid held -> outputs bit-stable and `stall_cnt=5`.
  - Skid build: accepts exactly 1 extra word, then `in_ready=0`.
  - No-skid build: `in_ready=0` immediately.
- Flush while stalled with skid full -> next cycle `out_valid=0`, `out_ctrl=NOP_CTRL`, `out_ops=0`, `in_ready=1`, and the skid word is never emitted.
- Saturation with `CNT_W=4`: stall 20 cycles -> `stall_cnt=15`.
- Async reset asserted mid-stall between clock edges -> outputs reset immediately. After release, the first accepted word appears with correct 1-cycle latency.
